// File: rtl/cci_mpf_pt_rsp_pkg.sv
// Shared types for the page-table read responder.
//   t_pt_idx       : PTE store index for the default 1024-line store
//   t_pt_line      : one 512-bit cache line
//   t_pt_rsp_entry : one slot of the response delay pipeline {valid, mdata, data, oob}
//   pt_rsp_fill()  : substitutes the all-ones line for out-of-bounds reads
package cci_mpf_pt_rsp_pkg;

  localparam int PT_RSP_MDATA_WIDTH = 16;
  localparam int PT_RSP_LINE_WIDTH  = 512;
  localparam int PT_RSP_N_ENTRIES   = 1024;
  localparam int PT_RSP_IDX_WIDTH   = $clog2(PT_RSP_N_ENTRIES);

  typedef logic [PT_RSP_IDX_WIDTH-1:0]  t_pt_idx;
  typedef logic [PT_RSP_LINE_WIDTH-1:0] t_pt_line;

  typedef struct packed {
    logic                          valid;
    logic [PT_RSP_MDATA_WIDTH-1:0] mdata;
    t_pt_line                      data;
    logic                          oob;
  } t_pt_rsp_entry;

  // Out-of-bounds requests still answer, but with a line of all ones so the
  // walker sees an obviously invalid PTE rather than a stale store entry.
  function automatic t_pt_line pt_rsp_fill(input logic oob, input t_pt_line data);
    return oob ? {PT_RSP_LINE_WIDTH{1'b1}} : data;
  endfunction

endpackage

// File: rtl/cci_mpf_pt_rd_responder_if.sv
// Request/response bus between the VTP page-table walker and its read responder.
//   master : walker side  (drives req_*, sees alm_full and rsp_*)
//   slave  : responder    (sees req_*, drives alm_full and rsp_*)
// rsp_* has no backpressure; the requester throttles itself on alm_full.
interface cci_mpf_pt_rd_responder_if #(
  parameter int MDATA_WIDTH   = 16,
  parameter int CL_ADDR_WIDTH = 42
);

  logic                     req_valid;
  logic [CL_ADDR_WIDTH-1:0] req_addr;
  logic [MDATA_WIDTH-1:0]   req_mdata;
  logic                     alm_full;
  logic                     rsp_valid;
  logic [MDATA_WIDTH-1:0]   rsp_mdata;
  logic [511:0]             rsp_data;

  modport master (
    output req_valid, req_addr, req_mdata,
    input  alm_full, rsp_valid, rsp_mdata, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, req_mdata,
    output alm_full, rsp_valid, rsp_mdata, rsp_data
  );

endinterface

// File: rtl/cci_mpf_pt_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// Ports:
//   clk, reset (sync, active-low: clears pointers and occupancy only)
//   push/push_data : write; caller guarantees !full || pop
//   pop/pop_data   : pop_data is the head entry whenever !empty
//   empty, full, occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module cci_mpf_pt_rsp_fifo #(
  parameter int WIDTH = 58,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data  = mem[rd_ptr];
  assign empty     = (cnt == '0);
  assign full      = (cnt == CNT_W'(DEPTH));
  assign occupancy = cnt;

endmodule

// File: rtl/cci_mpf_pt_rd_responder.sv
// Page-table read responder: stands in for host memory on the FIU side of the
// VTP shim. Walker reads are queued, looked up in a host-loadable PTE store
// and answered LATENCY cycles after leaving the queue, in request order, with
// Mdata (including the walker tag bit) echoed unchanged.
// Ports:
//   clk, reset        : clock; synchronous active-low reset
//   pt_base           : line address of store entry 0 (quasi-static)
//   bus (slave)       : req_valid/req_addr/req_mdata in, alm_full and
//                       rsp_valid/rsp_mdata/rsp_data out
//   ld_en/ld_idx/ld_data : store load port (ignored while in reset)
//   err_overflow      : sticky, a request arrived with the queue full
//   err_oob           : sticky, a request fell outside the store window
// Optional build macro MPF_PT_RSP_STATS_EN adds stat_reqs / stat_rsps.
module cci_mpf_pt_rd_responder
  import cci_mpf_pt_rsp_pkg::*;
#(
  parameter int N_ENTRIES      = 1024,
  parameter int LATENCY        = 4,
  parameter int FIFO_DEPTH     = 16,
  parameter int ALM_FULL_SLACK = 4,
  parameter int RSP_GAP        = 1,
  parameter int MDATA_WIDTH    = 16,
  parameter int CL_ADDR_WIDTH  = 42
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CL_ADDR_WIDTH-1:0]     pt_base,
  cci_mpf_pt_rd_responder_if.slave     bus,
  input  logic                         ld_en,
  input  logic [$clog2(N_ENTRIES)-1:0] ld_idx,
  input  logic [511:0]                 ld_data,
  output logic                         err_overflow,
  output logic                         err_oob
`ifdef MPF_PT_RSP_STATS_EN
  ,
  output logic [31:0]                  stat_reqs,
  output logic [31:0]                  stat_rsps
`endif
);

  localparam int IDX_W  = $clog2(N_ENTRIES);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int GAP_W  = (RSP_GAP > 1) ? $clog2(RSP_GAP) : 1;
  localparam int FIFO_W = CL_ADDR_WIDTH + MDATA_WIDTH;

  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic [CNT_W-1:0]         fifo_occ;
  logic [FIFO_W-1:0]        fifo_dout;
  logic [CNT_W-1:0]         occ_next;
  logic [GAP_W-1:0]         gap_cnt;
  logic                     alm_full_r;

  logic [CL_ADDR_WIDTH-1:0] head_addr;
  logic [MDATA_WIDTH-1:0]   head_mdata;
  logic [CL_ADDR_WIDTH-1:0] head_off;
  logic [IDX_W-1:0]         head_idx;
  logic                     head_oob;

  t_pt_line                 store [N_ENTRIES];
  t_pt_rsp_entry            entry_p0;
  t_pt_rsp_entry            dly_pn [LATENCY-1];
  t_pt_rsp_entry            out_pn;

  // A pop frees a slot in the same cycle, so a push onto a full queue is
  // still taken when it coincides with a pop.
  assign fifo_pop  = !fifo_empty && (gap_cnt == '0);
  assign fifo_push = reset && bus.req_valid && (!fifo_full || fifo_pop);

  cci_mpf_pt_rsp_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({bus.req_addr, bus.req_mdata}),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .occupancy (fifo_occ)
  );

  assign {head_addr, head_mdata} = fifo_dout;

  // Unsigned difference: addresses below pt_base wrap to huge offsets and
  // land in the out-of-bounds case along with those past the top.
  assign head_off = head_addr - pt_base;
  assign head_oob = (head_off >= CL_ADDR_WIDTH'(N_ENTRIES));
  assign head_idx = head_off[IDX_W-1:0];

  always_comb begin
    occ_next = fifo_occ;
    if (fifo_push && !fifo_pop)      occ_next = fifo_occ + 1'b1;
    else if (!fifo_push && fifo_pop) occ_next = fifo_occ - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      gap_cnt      <= '0;
      alm_full_r   <= 1'b0;
      err_overflow <= 1'b0;
      err_oob      <= 1'b0;
    end else begin
      if (fifo_pop)             gap_cnt <= GAP_W'(RSP_GAP - 1);
      else if (gap_cnt != '0)   gap_cnt <= gap_cnt - 1'b1;
      alm_full_r <= (occ_next >= CNT_W'(FIFO_DEPTH - ALM_FULL_SLACK));
      if (bus.req_valid && fifo_full && !fifo_pop) err_overflow <= 1'b1;
      if (fifo_pop && head_oob)                    err_oob      <= 1'b1;
    end
  end

  // Store contents survive reset; only loads are blocked while in reset.
  always_ff @(posedge clk) begin
    if (reset && ld_en) store[ld_idx] <= ld_data;
  end

  // ---- stage p0: store read in the pop cycle (read-before-write) ----
  always_ff @(posedge clk) begin
    entry_p0.mdata <= head_mdata;
    entry_p0.data  <= store[head_idx];
    entry_p0.oob   <= head_oob;
    if (!reset) entry_p0.valid <= 1'b0;
    else        entry_p0.valid <= fifo_pop;
  end

  // ---- stages p1..p(LATENCY-1): pure delay line ----
  always_ff @(posedge clk) begin
    dly_pn[0] <= entry_p0;
    for (int i = 1; i < LATENCY - 1; i++) dly_pn[i] <= dly_pn[i-1];
    if (!reset) begin
      for (int i = 0; i < LATENCY - 1; i++) dly_pn[i].valid <= 1'b0;
    end
  end

  // ---- output: data and mdata read as zero whenever no response is valid ----
  assign out_pn        = dly_pn[LATENCY-2];
  assign bus.rsp_valid = out_pn.valid;
  assign bus.rsp_mdata = out_pn.valid ? out_pn.mdata : '0;
  assign bus.rsp_data  = out_pn.valid ? pt_rsp_fill(out_pn.oob, out_pn.data) : '0;
  assign bus.alm_full  = alm_full_r;

`ifdef MPF_PT_RSP_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_reqs <= '0;
      stat_rsps <= '0;
    end else begin
      if (fifo_push)    stat_reqs <= stat_reqs + 32'd1;
      if (out_pn.valid) stat_rsps <= stat_rsps + 32'd1;
    end
  end
`endif

endmodule
